// File: rtl/div_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : div_pkg
//  Purpose  : Shared types, constants and helpers for the sequential signed
//             divider (state encoding, default width, widened absolute value).
//  Revision : 1.0 - initial release
// ============================================================================
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 8;

    // Widest operand the absolute-value helper accepts; callers sign-extend
    // into this width and truncate the result back to WIDTH+1 bits.
    localparam int DIV_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } div_state_t;

    // Magnitude of a two's-complement value with one extra bit, so the most
    // negative input keeps its full magnitude.
    function automatic logic [DIV_MAX_W:0] abs_ext(input logic signed [DIV_MAX_W-1:0] x);
        logic [DIV_MAX_W:0] w_wide;
        w_wide = {x[DIV_MAX_W-1], x};
        return x[DIV_MAX_W-1] ? (~w_wide + (DIV_MAX_W+1)'(1)) : w_wide;
    endfunction

endpackage
`default_nettype wire

// File: rtl/div_restore_step.sv
`default_nettype none
// ============================================================================
//  Module   : div_restore_step
//  Purpose  : One restoring-division iteration: shift the partial remainder
//             left, bring in the next dividend bit, trial-subtract |b| and keep
//             the difference when it is non-negative.
//  Revision : 1.0 - initial release
// ============================================================================
module div_restore_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH:0] i_rem,
    input  logic           i_bit,
    input  logic [WIDTH:0] i_abs_b,
    output logic [WIDTH:0] o_rem,
    output logic           o_qbit
);

    logic [WIDTH+1:0] w_shifted;

    // Shift-in, compare and conditionally subtract.
    always_comb begin
        w_shifted = {i_rem, i_bit};
        o_qbit    = (w_shifted >= {1'b0, i_abs_b});
        o_rem     = o_qbit ? (WIDTH+1)'(w_shifted - {1'b0, i_abs_b})
                           : (WIDTH+1)'(w_shifted);
    end

endmodule
`default_nettype wire

// File: rtl/seq_signed_divider.sv
`default_nettype none
// ============================================================================
//  Module   : seq_signed_divider
//  Purpose  : Multi-cycle signed divider, one quotient bit per clock using the
//             restoring algorithm on magnitudes, signs applied in a final step.
//             Start/done handshake; divide-by-zero and overflow flags.
//  Revision : 1.0 - initial release
// ============================================================================
module seq_signed_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero,
    output logic             overflow
);

    localparam int CW = $clog2(WIDTH + 1);

    div_state_t       r_state;
    div_state_t       w_next_state;

    logic [CW-1:0]    r_count;
    logic [WIDTH:0]   r_abs_a;      // dividend magnitude, shifted out MSB first
    logic [WIDTH:0]   r_abs_b;
    logic [WIDTH:0]   r_rem;        // partial remainder magnitude
    logic [WIDTH-1:0] r_qmag;       // quotient magnitude being assembled
    logic [WIDTH-1:0] r_a;          // original dividend for the div-by-zero result
    logic             r_sign_q;
    logic             r_sign_r;
    logic             r_dbz_p;
    logic             r_ovf_p;

    logic [WIDTH-1:0] r_quotient;
    logic [WIDTH-1:0] r_remainder;
    logic             r_done;
    logic             r_dbz;
    logic             r_ovf;

    logic [WIDTH:0]   w_abs_a;
    logic [WIDTH:0]   w_abs_b;
    logic             w_div_zero;
    logic             w_is_ovf;
    logic             w_last_step;
    logic [WIDTH:0]   w_step_rem;
    logic             w_qbit;
    logic [WIDTH-1:0] w_rmag;

    assign w_abs_a     = (WIDTH+1)'(abs_ext(DIV_MAX_W'(signed'(dividend))));
    assign w_abs_b     = (WIDTH+1)'(abs_ext(DIV_MAX_W'(signed'(divisor))));
    assign w_div_zero  = (divisor == '0);
    assign w_is_ovf    = (dividend == {1'b1, {(WIDTH-1){1'b0}}}) && (&divisor);
    assign w_last_step = (r_count == CW'(WIDTH - 1));
    // Partial remainder is always below |b| <= 2^(W-1), so W bits hold it.
    assign w_rmag      = WIDTH'(r_rem);

    div_restore_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .i_rem   (r_rem),
        .i_bit   (r_abs_a[WIDTH-1]),
        .i_abs_b (r_abs_b),
        .o_rem   (w_step_rem),
        .o_qbit  (w_qbit)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: zero divisors skip the iteration entirely.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_next_state = w_div_zero ? FIX : CALC;
                end
            end
            CALC: begin
                if (w_last_step) begin
                    w_next_state = FIX;
                end
            end
            FIX:     w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    // Operand capture, iteration datapath and sign-corrected result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_abs_a     <= '0;
            r_abs_b     <= '0;
            r_rem       <= '0;
            r_qmag      <= '0;
            r_a         <= '0;
            r_sign_q    <= 1'b0;
            r_sign_r    <= 1'b0;
            r_dbz_p     <= 1'b0;
            r_ovf_p     <= 1'b0;
            r_quotient  <= '0;
            r_remainder <= '0;
            r_done      <= 1'b0;
            r_dbz       <= 1'b0;
            r_ovf       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_abs_a  <= w_abs_a;
                        r_abs_b  <= w_abs_b;
                        r_a      <= dividend;
                        r_sign_q <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        r_sign_r <= dividend[WIDTH-1];
                        r_dbz_p  <= w_div_zero;
                        r_ovf_p  <= w_is_ovf;
                        r_rem    <= '0;
                        r_qmag   <= '0;
                        r_count  <= '0;
                    end
                end
                CALC: begin
                    r_rem   <= w_step_rem;
                    r_qmag  <= {r_qmag[WIDTH-2:0], w_qbit};
                    r_abs_a <= r_abs_a << 1;
                    r_count <= r_count + CW'(1);
                end
                FIX: begin
                    if (r_dbz_p) begin
                        r_quotient  <= '1;
                        r_remainder <= r_a;
                    end else begin
                        // A magnitude of 2^(W-1) wraps to the most negative value.
                        r_quotient  <= r_sign_q ? -r_qmag : r_qmag;
                        r_remainder <= r_sign_r ? -w_rmag : w_rmag;
                    end
                    r_dbz  <= r_dbz_p;
                    r_ovf  <= r_ovf_p;
                    r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy        = (r_state != IDLE);
    assign done        = r_done;
    assign quotient    = r_quotient;
    assign remainder   = r_remainder;
    assign div_by_zero = r_dbz;
    assign overflow    = r_ovf;

endmodule
`default_nettype wire

// File: tb/tb_seq_signed_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seq_signed_divider
//  Purpose  : Scoreboard bench for seq_signed_divider (WIDTH=8): directed
//             cases, ignored start, back-to-back start, async reset abort,
//             diagonal sweep and random operands against an arithmetic model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_seq_signed_divider;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        logic         ovf;
    } exp_t;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;
    logic         overflow;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    seq_signed_divider #(
        .WIDTH (W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain signed integer division (truncating) plus the two
    // special cases.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   ai;
        int   bi;
        ai    = int'(signed'(a));
        bi    = int'(signed'(b));
        e.a   = a;
        e.b   = b;
        e.dbz = 1'b0;
        e.ovf = 1'b0;
        if (bi == 0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else if (ai == -(1 << (W - 1)) && bi == -1) begin
            e.q   = a;
            e.r   = '0;
            e.ovf = 1'b1;
        end else begin
            e.q = W'(ai / bi);
            e.r = W'(ai % bi);
        end
        return e;
    endfunction

    // Monitor: every done pops one expectation.
    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("quotient", 32'(quotient), 32'(e.q));
                chk("remainder", 32'(remainder), 32'(e.r));
                chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                chk("overflow", 32'(overflow), 32'(e.ovf));
                if (!e.dbz && !e.ovf) begin
                    chk("invariant_qb_plus_r",
                        32'(int'(signed'(quotient)) * int'(signed'(e.b)) + int'(signed'(remainder))),
                        32'(int'(signed'(e.a))));
                end
            end
        end
    end

    // Issue one transaction from a negedge with the DUT idle, optionally
    // pulse a second start at cycle inj (ignored while busy), and check
    // latency and busy duration. Returns on the done negedge.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int inj);
        int k;
        int bc;
        int lat;
        sb.push_back(model(a, b));
        lat      = (b == '0) ? 2 : W + 2;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        dividend = W'($urandom);
        divisor  = W'($urandom);
        k  = 1;
        bc = 0;
        while (!done && k < 50) begin
            if (busy) bc++;
            start = (k == inj);
            if (k == inj) begin
                dividend = 8'd50;
                divisor  = 8'd3;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk("done_latency", 32'(k), 32'(lat));
        chk("busy_cycles", 32'(bc), 32'(lat - 1));
        chk("busy_low_at_done", 32'(busy), 32'd0);
    endtask

    initial begin
        int wait_cnt;
        rst_n    = 1'b0;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quotient", 32'(quotient), 32'd0);
        chk("rst_remainder", 32'(remainder), 32'd0);
        chk("rst_flags", 32'({div_by_zero, overflow}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        run_op(8'd100, 8'd7, 0);
        run_op(-8'sd100, 8'd7, 0);
        run_op(8'd100, -8'sd7, 0);
        run_op(-8'sd100, -8'sd7, 0);
        run_op(8'h80, 8'hFF, 0);
        run_op(8'h80, 8'd1, 0);
        run_op(8'd5, 8'd0, 0);
        run_op(8'h80, 8'd0, 0);
        run_op(8'd127, 8'h80, 0);
        run_op(8'h80, 8'h80, 0);

        // Start pulsed mid-transaction is ignored; the next op starts in
        // the done cycle.
        run_op(8'd100, 8'd7, 3);
        run_op(8'd77, 8'd9, 0);

        // Async reset mid-CALC clears outputs immediately, no done follows.
        dividend = 8'd5;
        divisor  = 8'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_quotient", 32'(quotient), 32'd0);
        chk("abort_remainder", 32'(remainder), 32'd0);
        chk("abort_flags", 32'({div_by_zero, overflow}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_op(8'd100, 8'd7, 0);

        // Diagonal sweep a = b = i over all 256 values.
        for (int i = 0; i < 256; i++) begin
            run_op(W'(i), W'(i), 0);
        end

        // Random operands with corner values mixed in.
        for (int i = 0; i < 300; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            ra = W'($urandom);
            rb = W'($urandom);
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: ra = 8'h80;
                2: rb = 8'hFF;
                3: rb = 8'd1;
                default: ;
            endcase
            run_op(ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 0);
        end

        wait_cnt = 0;
        while (sb.size() != 0 && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
